// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg: shared stage state encoding
package pipe_stage_skid_pkg;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2} state_t;
endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// sat_counter: saturating up-counter with clear that beats increment
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with optional 2-entry skid buffer and perf counters
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
);
  state_t            state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              ready_q;
  assign in_ready  = (SKID != 0) ? ready_q : (state != ST_FULL || out_ready);
  assign out_valid = state != ST_EMPTY;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  always_ff @(posedge clk)
    if (rst || flush) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      ready_q   <= 1'b1;
    end else if (state == ST_SKID) begin
      if (out_ready) begin
        state     <= ST_FULL;
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
        skid_data <= '0;
        skid_ctrl <= '0;
        ready_q   <= 1'b1;
      end
    end else if (in_valid && (state == ST_EMPTY || out_ready)) begin
      state     <= ST_FULL;
      main_data <= in_data;
      main_ctrl <= in_ctrl;
    end else if (in_valid && SKID != 0) begin
      state     <= ST_SKID;
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
      ready_q   <= 1'b0;
    end else if (state == ST_FULL && out_ready) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(out_valid && !out_ready), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_xfer (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(out_valid && out_ready), .cnt(xfer_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: queue-model scoreboard for skid, no-skid and narrow-counter stages
module tb_pipe_stage_skid;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, flush, cnt_clr;
  logic [31:0] in_data;
  logic [3:0] in_ctrl;
  logic ov [3];
  logic ir [3];
  logic [31:0] od [3];
  logic [3:0] oc [3];
  logic [15:0] sc [2];
  logic [15:0] xc [2];
  logic [1:0] sc2, xc2;
  logic [35:0] exp_q [2][$];
  int m_sc [3];
  int m_xc [3];
  bit armed = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_stage_skid #(.SKID(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]), .flush(flush),
    .cnt_clr(cnt_clr), .stall_cnt(sc[0]), .xfer_cnt(xc[0])
  );
  pipe_stage_skid #(.SKID(0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]), .flush(flush),
    .cnt_clr(cnt_clr), .stall_cnt(sc[1]), .xfer_cnt(xc[1])
  );
  pipe_stage_skid #(.SKID(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_ctrl(oc[2]), .flush(flush),
    .cnt_clr(cnt_clr), .stall_cnt(sc2), .xfer_cnt(xc2)
  );
  task automatic chk(input string name, input int i, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s u%0d at %0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [35:0] head [3];
    bit v [3];
    bit r [3];
    int lim;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (i == 2) ? 0 : i;
      v[i] = exp_q[k].size() != 0;
      head[i] = v[i] ? exp_q[k][0] : 36'd0;
      r[i] = (i == 1) ? (!v[i] || out_ready) : (exp_q[k].size() < 2);
    end
    if (armed)
      for (int i = 0; i < 3; i++) begin
        chk("out_valid", i, longint'(ov[i]), longint'(v[i]));
        chk("out_data", i, longint'(od[i]), longint'(head[i][31:0]));
        chk("out_ctrl", i, longint'(oc[i]), longint'(head[i][35:32]));
        chk("in_ready", i, longint'(ir[i]), longint'(r[i]));
        chk("stall_cnt", i, (i == 2) ? longint'(sc2) : longint'(sc[i]), longint'(m_sc[i]));
        chk("xfer_cnt", i, (i == 2) ? longint'(xc2) : longint'(xc[i]), longint'(m_xc[i]));
      end
    for (int i = 0; i < 3; i++) begin
      lim = (i == 2) ? 3 : 65535;
      if (rst || cnt_clr) begin
        m_sc[i] = 0;
        m_xc[i] = 0;
      end else begin
        if (v[i] && !out_ready && m_sc[i] < lim) m_sc[i]++;
        if (v[i] && out_ready && m_xc[i] < lim) m_xc[i]++;
      end
    end
    for (int k = 0; k < 2; k++)
      if (rst || flush) exp_q[k].delete();
      else begin
        if (v[k] && out_ready) void'(exp_q[k].pop_front());
        if (in_valid && r[k]) exp_q[k].push_back({in_ctrl, in_data});
      end
    if (rst) armed = 1'b1;
  end
  task automatic cyc(input bit v, input logic [31:0] d, input logic [3:0] c, input bit ordy,
                     input bit fl = 0, input bit clr = 0, input bit r = 0);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl; cnt_clr = clr; rst = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_ctrl = 0; out_ready = 0; flush = 0; cnt_clr = 0;
    for (int i = 0; i < 3; i++) begin m_sc[i] = 0; m_xc[i] = 0; end
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 32'h1234_5678, 4'b0101, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 32'hA, 4'h1, 0);
    cyc(1, 32'hB, 4'h2, 0);
    cyc(1, 32'hC, 4'h3, 0);
    cyc(1, 32'hC, 4'h3, 1);
    cyc(1, 32'hC, 4'h3, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 32'hD, 4'hF, 0);
    cyc(1, 32'hE, 4'hF, 0);
    cyc(1, 32'hF, 4'hF, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 32'h100 + 32'(i), 4'(i), 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 32'h55, 4'h9, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 32'h77, 4'h7, 0);
    cyc(1, 32'h88, 4'h8, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 99) < 60, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 99) < 65,
          $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 1, $urandom_range(0, 199) < 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
